// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : Shared types and redirect source codes for the PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // Numeric order of the source codes is the arbitration priority.
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_J    = 2'd1;
    localparam logic [1:0] SRC_JR   = 2'd2;
    localparam logic [1:0] SRC_BR   = 2'd3;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] tgt;
        logic        mis;
    } redirect_t;

    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/jump_target_gen.sv
// ============================================================================
// Module   : jump_target_gen
// Brief    : Builds the J/JAL target from the jump index and PC+4 region.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_target_gen (
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JumpPC4,
    output logic [31:0] JumpTarget
);

    logic [27:0] w_idx_shifted;
    logic        w_unused_pc4;

    assign w_idx_shifted = {JumpIndex, 2'b00};
    assign JumpTarget    = {JumpPC4[31:28], w_idx_shifted};
    assign w_unused_pc4  = ^JumpPC4[27:0];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter with prioritised redirects and a one-entry
//            pending buffer that holds a redirect across pipeline stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             JumpReq,
    input  logic [25:0]      JumpIndex,
    input  logic [31:0]      JumpPC4,
    input  logic             JrReq,
    input  logic [31:0]      JrAddr,
    input  logic             BranchReq,
    input  logic [31:0]      BranchTarget,
    output logic [31:0]      PCResult,
    output logic [31:0]      PCPlus4,
    output logic             FlushIF,
    output logic             FlushID,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] RedirectCount
);

    state_t           r_state;
    state_t           w_state_nxt;
    redirect_t        r_pend;
    redirect_t        w_pend_nxt;
    redirect_t        w_req;
    redirect_t        w_win;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_jtgt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_apply;
    logic             w_unused_bt;

    jump_target_gen u_jump_target_gen (
        .JumpIndex  (JumpIndex),
        .JumpPC4    (JumpPC4),
        .JumpTarget (w_jtgt)
    );

    assign w_unused_bt = ^BranchTarget[1:0];
    assign PCPlus4     = r_pc + 32'd4;

    // Branch is the older instruction, so it outranks JR, which outranks J.
    always_comb begin
        w_req = '0;
        if (BranchReq) begin
            w_req.src = SRC_BR;
            w_req.tgt = align4(BranchTarget);
        end else if (JrReq) begin
            w_req.src = SRC_JR;
            w_req.tgt = align4(JrAddr);
            w_req.mis = |JrAddr[1:0];
        end else if (JumpReq) begin
            w_req.src = SRC_J;
            w_req.tgt = w_jtgt;
        end
    end

    always_comb begin
        w_win       = w_req;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_pc_nxt    = r_pc;
        w_apply     = 1'b0;

        // A buffered redirect yields only to a strictly higher-priority one.
        if (r_state == S_PEND && w_req.src <= r_pend.src) begin
            w_win = r_pend;
        end

        if (!Stall) begin
            if (w_win.src != SRC_NONE) begin
                w_apply  = 1'b1;
                w_pc_nxt = w_win.tgt;
            end else begin
                w_pc_nxt = PCPlus4;
            end
            w_state_nxt = S_RUN;
            w_pend_nxt  = '0;
        end else if (w_win.src != SRC_NONE) begin
            w_pend_nxt  = w_win;
            w_state_nxt = S_PEND;
        end
    end

    assign FlushIF     = Reset & w_apply;
    assign FlushID     = Reset & w_apply & (w_win.src == SRC_BR);
    assign MisalignErr = Reset & w_apply & (w_win.src == SRC_JR) & w_win.mis;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pend <= '0;
            r_pc   <= RESET_PC;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_pc   <= w_pc_nxt;
            if (w_apply && r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign PCResult      = r_pc;
    assign RedirectCount = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed and randomised bench for pc_sequencer with a
//            behavioural model of the redirect rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic             Stall;
    logic             JumpReq;
    logic [25:0]      JumpIndex;
    logic [31:0]      JumpPC4;
    logic             JrReq;
    logic [31:0]      JrAddr;
    logic             BranchReq;
    logic [31:0]      BranchTarget;
    logic [31:0]      PCResult;
    logic [31:0]      PCPlus4;
    logic             FlushIF;
    logic             FlushID;
    logic             MisalignErr;
    logic [CNT_W-1:0] RedirectCount;

    int n_cmp;
    int n_bad;

    // Model state: current PC, optional buffered redirect, redirect tally.
    logic [31:0]      m_pc;
    bit               m_pv;
    int               m_psrc;
    logic [31:0]      m_ptgt;
    bit               m_pmis;
    logic [CNT_W-1:0] m_cnt;
    int               e_src;
    logic [31:0]      e_tgt;
    bit               e_mis;
    bit               x_fif;
    bit               x_fid;
    bit               x_mis;

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Stall         (Stall),
        .JumpReq       (JumpReq),
        .JumpIndex     (JumpIndex),
        .JumpPC4       (JumpPC4),
        .JrReq         (JrReq),
        .JrAddr        (JrAddr),
        .BranchReq     (BranchReq),
        .BranchTarget  (BranchTarget),
        .PCResult      (PCResult),
        .PCPlus4       (PCPlus4),
        .FlushIF       (FlushIF),
        .FlushID       (FlushID),
        .MisalignErr   (MisalignErr),
        .RedirectCount (RedirectCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void model_reset();
        m_pc   = 32'h0;
        m_pv   = 0;
        m_psrc = 0;
        m_ptgt = 32'h0;
        m_pmis = 0;
        m_cnt  = '0;
    endfunction

    // Priorities: branch 3, JR 2, J 1; a pending entry keeps ties.
    function automatic void model_eval();
        int rs;
        logic [31:0] rt;
        bit rm;
        rs = 0; rt = 32'h0; rm = 0;
        if (BranchReq) begin
            rs = 3; rt = BranchTarget & 32'hFFFF_FFFC;
        end else if (JrReq) begin
            rs = 2; rt = JrAddr & 32'hFFFF_FFFC; rm = (JrAddr[1:0] != 2'b00);
        end else if (JumpReq) begin
            rs = 1; rt = {JumpPC4[31:28], JumpIndex, 2'b00};
        end
        e_src = rs; e_tgt = rt; e_mis = rm;
        if (m_pv && m_psrc >= rs) begin
            e_src = m_psrc; e_tgt = m_ptgt; e_mis = m_pmis;
        end
        x_fif = Reset && !Stall && (e_src != 0);
        x_fid = x_fif && (e_src == 3);
        x_mis = x_fif && (e_src == 2) && e_mis;
    endfunction

    function automatic void model_tick();
        if (!Reset) return;
        if (!Stall) begin
            if (e_src != 0) begin
                m_pc = e_tgt;
                if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_pv = 0;
        end else if (e_src != 0) begin
            m_pv = 1; m_psrc = e_src; m_ptgt = e_tgt; m_pmis = e_mis;
        end
    endfunction

    task automatic drive(input bit rst, input bit st, input bit jq, input logic [25:0] ji,
                         input logic [31:0] jp, input bit jrq, input logic [31:0] ja,
                         input bit bq, input logic [31:0] bt);
        Reset = rst; Stall = st;
        JumpReq = jq; JumpIndex = ji; JumpPC4 = jp;
        JrReq = jrq; JrAddr = ja;
        BranchReq = bq; BranchTarget = bt;
        if (!rst) model_reset();
        #3;
        model_eval();
    endtask

    task automatic idle(input bit st);
        drive(1, st, 0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic tick();
        model_tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 26'h1, 32'h0, 1, 32'h3, 1, 32'h500);
        n_cmp++; if (PCResult !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", PCResult, 32'h0); end
        n_cmp++; if (FlushIF !== 1'b0 || FlushID !== 1'b0 || MisalignErr !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got %b%b%b want 000", FlushIF, FlushID, MisalignErr); end
        n_cmp++; if (RedirectCount !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", RedirectCount); end
        tick();
        drive(0, 0, 1, 26'h1, 32'h0, 1, 32'h3, 1, 32'h500);
        n_cmp++; if (PCResult !== 32'h0 || FlushIF !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got pc %h fif %b want 0 0", PCResult, FlushIF); end
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(0);
            n_cmp++; if (PCResult !== 32'(i * 4)) begin n_bad++; $display("FAIL free_pc%0d: got %h want %h", i, PCResult, 32'(i * 4)); end
            n_cmp++; if (FlushIF !== 1'b0 || FlushID !== 1'b0 || RedirectCount !== 4'd0) begin n_bad++; $display("FAIL free_misc%0d: got fif %b fid %b cnt %0d want 0 0 0", i, FlushIF, FlushID, RedirectCount); end
            tick();
        end
    endtask

    task automatic test_jump();
        drive(1, 0, 1, 26'h000_0040, 32'h1000_0014, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (PCResult !== 32'h10) begin n_bad++; $display("FAIL jump_start_pc: got %h want %h", PCResult, 32'h10); end
        n_cmp++; if (FlushIF !== 1'b1 || FlushID !== 1'b0) begin n_bad++; $display("FAIL jump_flush: got %b%b want 10", FlushIF, FlushID); end
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'h1000_0100) begin n_bad++; $display("FAIL jump_pc: got %h want %h", PCResult, 32'h1000_0100); end
        n_cmp++; if (RedirectCount !== 4'd1) begin n_bad++; $display("FAIL jump_cnt: got %0d want 1", RedirectCount); end
    endtask

    task automatic test_branch_jr();
        drive(1, 0, 0, 26'h0, 32'h0, 1, 32'h300, 1, 32'h200);
        n_cmp++; if (FlushIF !== 1'b1 || FlushID !== 1'b1 || MisalignErr !== 1'b0) begin n_bad++; $display("FAIL brjr_flush: got %b%b%b want 110", FlushIF, FlushID, MisalignErr); end
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'h200) begin n_bad++; $display("FAIL brjr_pc: got %h want %h", PCResult, 32'h200); end
    endtask

    task automatic test_stall_pending();
        drive(1, 1, 1, 26'h100, 32'h0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (PCResult !== 32'h200 || FlushIF !== 1'b0) begin n_bad++; $display("FAIL stall1: got pc %h fif %b want 200 0", PCResult, FlushIF); end
        tick();
        drive(1, 1, 0, 26'h0, 32'h0, 0, 32'h0, 1, 32'h500);
        n_cmp++; if (PCResult !== 32'h200 || FlushIF !== 1'b0) begin n_bad++; $display("FAIL stall2: got pc %h fif %b want 200 0", PCResult, FlushIF); end
        tick();
        idle(1);
        n_cmp++; if (PCResult !== 32'h200 || FlushIF !== 1'b0) begin n_bad++; $display("FAIL stall3: got pc %h fif %b want 200 0", PCResult, FlushIF); end
        tick();
        idle(0);
        n_cmp++; if (FlushIF !== 1'b1 || FlushID !== 1'b1) begin n_bad++; $display("FAIL stall_release_flush: got %b%b want 11", FlushIF, FlushID); end
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'h500 || FlushIF !== 1'b0) begin n_bad++; $display("FAIL stall_pc: got pc %h fif %b want 500 0", PCResult, FlushIF); end
        n_cmp++; if (RedirectCount !== 4'd3) begin n_bad++; $display("FAIL stall_cnt: got %0d want 3", RedirectCount); end
    endtask

    task automatic test_reset_pending();
        drive(1, 1, 0, 26'h0, 32'h0, 1, 32'h602, 0, 32'h0);
        tick();
        drive(0, 1, 0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (PCResult !== 32'h0) begin n_bad++; $display("FAIL rstpend_pc: got %h want 0", PCResult); end
        tick();
        idle(0);
        n_cmp++; if (FlushIF !== 1'b0 || MisalignErr !== 1'b0 || PCResult !== 32'h0) begin n_bad++; $display("FAIL rstpend_drop: got fif %b mis %b pc %h want 0 0 0", FlushIF, MisalignErr, PCResult); end
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'h4 || RedirectCount !== 4'd0) begin n_bad++; $display("FAIL rstpend_after: got pc %h cnt %0d want 4 0", PCResult, RedirectCount); end
        drive(1, 1, 0, 26'h0, 32'h0, 1, 32'h602, 0, 32'h0);
        tick();
        idle(0);
        n_cmp++; if (FlushIF !== 1'b1 || FlushID !== 1'b0 || MisalignErr !== 1'b1) begin n_bad++; $display("FAIL misalign_pulse: got %b%b%b want 101", FlushIF, FlushID, MisalignErr); end
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'h600 || MisalignErr !== 1'b0) begin n_bad++; $display("FAIL misalign_after: got pc %h mis %b want 600 0", PCResult, MisalignErr); end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 26'h0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_plus4: got pc %h pc4 %h want fffffffc 0", PCResult, PCPlus4); end
        tick();
        idle(0);
        n_cmp++; if (PCResult !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got %h want 0", PCResult); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 26'h0, 32'h0, 1, 32'h700, 0, 32'h0);
            tick();
        end
        idle(0);
        n_cmp++; if (RedirectCount !== 4'hF) begin n_bad++; $display("FAIL sat_full: got %0d want 15", RedirectCount); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 26'h10, 32'h0, 0, 32'h0, 0, 32'h0);
            tick();
        end
        idle(0);
        n_cmp++; if (RedirectCount !== 4'hF) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", RedirectCount); end
    endtask

    task automatic test_random();
        logic [31:0] r0, r1, r2, r3;
        bit rst, st, jq, jrq, bq;
        for (int i = 0; i < 600; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            rst = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 9) < 4);
            jq  = ($urandom_range(0, 9) < 3);
            jrq = ($urandom_range(0, 9) < 2);
            bq  = ($urandom_range(0, 9) < 2);
            drive(rst, st, jq, r0[25:0], r1, jrq, r2, bq, r3);
            n_cmp++;
            if (PCResult !== m_pc || PCPlus4 !== m_pc + 32'd4 || FlushIF !== x_fif || FlushID !== x_fid
                || MisalignErr !== x_mis || RedirectCount !== m_cnt) begin
                n_bad++;
                $display("FAIL rand%0d: got pc %h pc4 %h fl %b%b mis %b cnt %0d want pc %h fl %b%b mis %b cnt %0d",
                         i, PCResult, PCPlus4, FlushIF, FlushID, MisalignErr, RedirectCount,
                         m_pc, x_fif, x_fid, x_mis, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        Reset = 1'b0; Stall = 1'b0;
        JumpReq = 1'b0; JumpIndex = '0; JumpPC4 = '0;
        JrReq = 1'b0; JrAddr = '0; BranchReq = 1'b0; BranchTarget = '0;
        @(posedge Clk);
        #1;
        test_reset();
        test_jump();
        test_branch_jr();
        test_stall_pending();
        test_reset_pending();
        test_wrap();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
